// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and reserved-result definitions for the alu_seq datapath.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ROR  = 4'd4,
        OP_ROL  = 4'd5,
        OP_SHR  = 4'd6,
        OP_SHRA = 4'd7,
        OP_SHL  = 4'd8,
        OP_DIV  = 4'd9,
        OP_MUL  = 4'd10,
        OP_NEG  = 4'd11,
        OP_NOT  = 4'd12
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Fill bit for C0/C1 on reserved opcodes (13-15, and 9 when the divider is absent).
    localparam logic RSV_C0_BIT = 1'b0;
    localparam logic RSV_C1_BIT = 1'b0;

endpackage

// File: rtl/alu_divider.sv
// Iterative signed restoring divider: magnitudes are divided one bit per cycle,
// then the quotient/remainder signs are restored (remainder follows the dividend).
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic             run_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic             neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] abs_a_d, abs_b_d;
    logic [WIDTH:0]   trial_d, diff_d;

    always_comb begin
        abs_a_d = a_i[WIDTH-1] ? ('0 - a_i) : a_i;
        abs_b_d = b_i[WIDTH-1] ? ('0 - b_i) : b_i;
        trial_d = {rem_q, quo_q[WIDTH-1]};
        diff_d  = trial_d - {1'b0, div_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= 1'b0;
            done_o    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i && !run_q) begin
                run_q     <= 1'b1;
                cnt_q     <= '0;
                rem_q     <= '0;
                quo_q     <= abs_a_d;
                div_q     <= abs_b_d;
                neg_quo_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                neg_rem_q <= a_i[WIDTH-1];
            end else if (run_q) begin
                // A borrow out of the trial subtraction means "restore".
                rem_q <= diff_d[WIDTH] ? trial_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], ~diff_d[WIDTH]};
                cnt_q <= cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    run_q  <= 1'b0;
                    done_o <= 1'b1;
                end
            end
        end
    end

    assign quot_o = neg_quo_q ? ('0 - quo_q) : quo_q;
    assign rem_o  = neg_rem_q ? ('0 - rem_q) : rem_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops, inline radix-2 Booth multiplier and an optional
// iterative divider enabled by defining ALU_SEQ_DIV_EN.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C0,
    output logic [WIDTH-1:0] C1,
    output logic             zero,
    output logic             dbz,
    output logic [2:0]       dbg_state_o
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0]       CNT_ONE  = (SHW + 1)'(1);
    localparam logic [SHW:0]       CNT_LAST = (SHW + 1)'(WIDTH - 1);
    localparam logic [SHW:0]       ROT_FULL = (SHW + 1)'(WIDTH);
    localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);

    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [SHW:0]     cnt_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             qm1_q;

    logic [SHW-1:0]   sh_d;
    logic [SHW:0]     rsh_d;
    logic [WIDTH-1:0] res_c0_d, res_c1_d;
    logic             res_dbz_d;
    logic [WIDTH:0]   hi_sum_d, hi_d;
    logic [WIDTH-1:0] lo_d;
    logic             qm1_d;
    logic             accept_d;

    assign accept_d    = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign dbg_state_o = state_q;

    always_comb begin
        sh_d      = b_q[SHW-1:0];
        rsh_d     = ROT_FULL - {1'b0, sh_d};
        res_c0_d  = {WIDTH{RSV_C0_BIT}};
        res_c1_d  = {WIDTH{RSV_C1_BIT}};
        res_dbz_d = 1'b0;
        case (op_q)
            OP_ADD:  res_c0_d = a_q + b_q;
            OP_SUB:  res_c0_d = a_q + ~b_q + ONE;
            OP_AND:  res_c0_d = a_q & b_q;
            OP_OR:   res_c0_d = a_q | b_q;
            OP_ROR:  res_c0_d = (a_q >> sh_d) | (a_q << rsh_d);
            OP_ROL:  res_c0_d = (a_q << sh_d) | (a_q >> rsh_d);
            OP_SHR:  res_c0_d = a_q >> sh_d;
            OP_SHRA: res_c0_d = $signed(a_q) >>> sh_d;
            OP_SHL:  res_c0_d = a_q << sh_d;
            OP_NEG:  res_c0_d = '0 - a_q;
            OP_NOT:  res_c0_d = ~a_q;
`ifdef ALU_SEQ_DIV_EN
            // Only the divide-by-zero case of div ever reaches the EXEC state.
            OP_DIV: begin
                res_c0_d  = '1;
                res_c1_d  = a_q;
                res_dbz_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // One Booth step: add/subtract the multiplicand, then arithmetic-shift {hi,lo,q-1}.
    always_comb begin
        hi_sum_d = hi_q;
        case ({lo_q[0], qm1_q})
            2'b01:   hi_sum_d = hi_q + {a_q[WIDTH-1], a_q};
            2'b10:   hi_sum_d = hi_q - {a_q[WIDTH-1], a_q};
            default: ;
        endcase
        hi_d  = {hi_sum_d[WIDTH], hi_sum_d[WIDTH:1]};
        lo_d  = {hi_sum_d[0], lo_q[WIDTH-1:1]};
        qm1_d = lo_q[0];
    end

`ifdef ALU_SEQ_DIV_EN
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quot, div_rem;

    assign div_start = accept_d && (control == OP_DIV) && (B != '0);

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .a_i     (A),
        .b_i     (B),
        .done_o  (div_done),
        .quot_o  (div_quot),
        .rem_o   (div_rem)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            C0      <= '0;
            C1      <= '0;
            zero    <= 1'b1;
            dbz     <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qm1_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_EXEC: begin
                    C0      <= res_c0_d;
                    C1      <= res_c1_d;
                    zero    <= (res_c0_d == '0);
                    dbz     <= res_dbz_d;
                    done    <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_MUL: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    qm1_q <= qm1_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        C0      <= lo_d;
                        C1      <= hi_d[WIDTH-1:0];
                        zero    <= (lo_d == '0);
                        dbz     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                ST_DIV: begin
                    if (div_done) begin
                        C0      <= div_quot;
                        C1      <= div_rem;
                        zero    <= (div_quot == '0);
                        dbz     <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
`endif
                default: begin
                    if (accept_d) begin
                        op_q  <= control;
                        a_q   <= A;
                        b_q   <= B;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        lo_q  <= B;
                        qm1_q <= 1'b0;
                        if (control == OP_MUL) begin
                            state_q <= ST_MUL;
                            busy    <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
                        end else if (control == OP_DIV && B != '0) begin
                            state_q <= ST_DIV;
                            busy    <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH = 32); div checks follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
  localparam int W = 32;

  localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_AND = 4'd2, C_OR = 4'd3;
  localparam logic [3:0] C_ROR = 4'd4, C_ROL = 4'd5, C_SHR = 4'd6, C_SHRA = 4'd7;
  localparam logic [3:0] C_SHL = 4'd8, C_DIV = 4'd9, C_MUL = 4'd10, C_NEG = 4'd11;
  localparam logic [3:0] C_NOT = 4'd12;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] A, B;
  logic [3:0]   control;
  logic         busy, done, zero, dbz;
  logic [W-1:0] C0, C1;
  logic [2:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .control(control),
    .busy(busy), .done(done), .C0(C0), .C1(C1), .zero(zero), .dbz(dbz),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver: called at a negedge, returns at the negedge where done is seen (or budget runs out)
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
    start = 1'b1; control = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic z, input logic d);
    logic [2*W-1:0] e;
    e = exp_q.pop_front();
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_c0"}, C0, e[W-1:0]);
    check_eq({tag, "_c1"}, C1, e[2*W-1:W]);
    check_eq({tag, "_zero"}, zero, z);
    check_eq({tag, "_dbz"}, dbz, d);
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c0;
    logic         z;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int lat, bcnt;
    logic saw_done;

    vecs[0]  = '{C_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[1]  = '{C_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
    vecs[2]  = '{C_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{C_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vecs[4]  = '{C_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
    vecs[5]  = '{C_SHRA, 32'h8000_0001, 32'd33,        32'hC000_0000, 1'b0};
    vecs[6]  = '{C_ROR,  32'h8000_0001, 32'd33,        32'hC000_0000, 1'b0};
    vecs[7]  = '{C_ROL,  32'h8000_0001, 32'd33,        32'h0000_0003, 1'b0};
    vecs[8]  = '{C_SHR,  32'h8000_0000, 32'd31,        32'h0000_0001, 1'b0};
    vecs[9]  = '{C_SHL,  32'h0000_0001, 32'd4,         32'h0000_0010, 1'b0};
    vecs[10] = '{C_NEG,  32'h0000_0005, 32'h0,         32'hFFFF_FFFB, 1'b0};
    vecs[11] = '{C_NEG,  32'h8000_0000, 32'h0,         32'h8000_0000, 1'b0};
    vecs[12] = '{C_NOT,  32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{4'd13,  32'h1234_5678, 32'h9,         32'h0000_0000, 1'b1};
    vecs[14] = '{4'd15,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[15] = '{C_ROR,  32'h1234_5678, 32'd32,        32'h1234_5678, 1'b0};
    vecs[16] = '{C_ROL,  32'h1234_5678, 32'd4,         32'h2345_6781, 1'b0};

    // reset, with a start asserted at the same time
    rst = 1'b1; start = 1'b1; control = C_ADD; A = 32'h1; B = 32'h1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_c0", C0, 0);
    check_eq("rst_c1", C1, 0);
    check_eq("rst_zero", zero, 1);
    check_eq("rst_dbz", dbz, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // single-cycle ops, issued back-to-back in each DONE cycle
    foreach (vecs[i]) begin
      exp_q.push_back({{W{1'b0}}, vecs[i].c0});
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      check_eq($sformatf("v%0d_lat", i), lat, 1);
      check_eq($sformatf("v%0d_busy", i), bcnt, 0);
      check_result($sformatf("v%0d", i), vecs[i].z, 1'b0);
    end

    // done is a single pulse and results hold afterwards
    @(negedge clk);
    check_eq("pulse_done", done, 0);
    repeat (4) @(negedge clk);
    check_eq("hold_c0", C0, 32'h2345_6781);
    check_eq("hold_c1", C1, 0);

    // Booth multiplier
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    run_op(C_MUL, 32'hFFFF_FFFD, 32'h0000_0007, lat, bcnt);
    check_eq("mul1_busy", bcnt, 32);
    check_eq("mul1_lat", lat, 32);
    check_result("mul1", 1'b0, 1'b0);

    exp_q.push_back(64'h3FFF_FFFF_0000_0001);
    run_op(C_MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat, bcnt);
    check_result("mul2", 1'b0, 1'b0);

    exp_q.push_back(64'h4000_0000_0000_0000);
    run_op(C_MUL, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
    check_result("mul3", 1'b1, 1'b0);

`ifdef ALU_SEQ_DIV_EN
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(C_DIV, 32'hFFFF_FFF9, 32'h0000_0002, lat, bcnt);
    check_eq("div1_busy", bcnt >= 32, 1);
    check_result("div1", 1'b0, 1'b0);

    exp_q.push_back({32'h1234_5678, 32'hFFFF_FFFF});
    run_op(C_DIV, 32'h1234_5678, 32'h0, lat, bcnt);
    check_eq("dbz_lat", lat, 1);
    check_eq("dbz_busy", bcnt, 0);
    check_result("dbz", 1'b0, 1'b1);

    exp_q.push_back({32'h0, 32'h0000_0002});
    run_op(C_ADD, 32'h1, 32'h1, lat, bcnt);
    check_result("dbz_clr", 1'b0, 1'b0);

    exp_q.push_back({32'h0, 32'h8000_0000});
    run_op(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
    check_result("div_ovf", 1'b0, 1'b0);

    exp_q.push_back({32'h0000_0002, 32'hFFFF_FFF2});
    run_op(C_DIV, 32'd100, 32'hFFFF_FFF9, lat, bcnt);
    check_result("div2", 1'b0, 1'b0);
`else
    exp_q.push_back(64'h0);
    run_op(C_DIV, 32'h1234_5678, 32'h0, lat, bcnt);
    check_eq("div_rsv_lat", lat, 1);
    check_eq("div_rsv_busy", bcnt, 0);
    check_result("div_rsv", 1'b1, 1'b0);
`endif

    // start during a multiply is ignored
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    start = 1'b1; control = C_MUL; A = 32'hFFFF_FFFD; B = 32'h7;
    @(negedge clk);
    start = 1'b0; lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) bcnt++;
      if (lat == 4) begin
        start = 1'b1; control = C_ADD; A = 32'h1; B = 32'h1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check_eq("ign_busy", bcnt, 32);
    check_result("ign", 1'b0, 1'b0);
    @(negedge clk);
    check_eq("ign_idle_done", done, 0);
    check_eq("ign_idle_busy", busy, 0);

    // reset on busy cycle 10 of a multiply
    start = 1'b1; control = C_MUL; A = 32'h5; B = 32'h3;
    @(negedge clk);
    start = 1'b0;
    check_eq("abort_busy_start", busy, 1);
    repeat (9) @(negedge clk);
    check_eq("abort_busy_c10", busy, 1);
    rst = 1'b1; start = 1'b1; control = C_ADD; A = 32'h1; B = 32'h1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_c0", C0, 0);
    check_eq("abort_zero", zero, 1);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check_eq("abort_quiet", saw_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
